// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one sequential divider between NUM_REQ requesters.
// A watchdog aborts any divide that the divider does not finish within TIMEOUT cycles.
module divider_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_dividend,
  input  logic [NUM_REQ*DATA_W-1:0] req_divisor,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_quotient,
  output logic [DATA_W-1:0]         rsp_remainder,
  output logic                      rsp_dbz,
  output logic                      rsp_timeout,
  output logic                      ctrl_busy,
  output logic                      div_start,
  output logic [DATA_W-1:0]         div_dividend,
  output logic [DATA_W-1:0]         div_divisor,
  input  logic                      div_busy,
  input  logic                      div_done,
  input  logic [DATA_W-1:0]         div_quotient,
  input  logic [DATA_W-1:0]         div_remainder,
  input  logic                      div_dbz
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0]       NREQ_EXT = (PTR_W + 1)'(NUM_REQ);
  localparam logic [WD_W-1:0]      WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [NUM_REQ-1:0]   ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [DATA_W-1:0]  dividend_q, dividend_d;
  logic [DATA_W-1:0]  divisor_q, divisor_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_quotient_q, rsp_quotient_d;
  logic [DATA_W-1:0]  rsp_remainder_q, rsp_remainder_d;
  logic               rsp_dbz_q, rsp_dbz_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               ctrl_busy_q, ctrl_busy_d;
  logic               div_start_q, div_start_d;

  logic               found_s;
  logic [PTR_W-1:0]   win_s;
  logic [PTR_W-1:0]   win_next_s;
  logic [WD_W-1:0]    wdog_inc_s;
  logic [DATA_W-1:0]  dvd_arr_s [NUM_REQ];
  logic [DATA_W-1:0]  dvs_arr_s [NUM_REQ];

  // The divider's busy flag is informational only; sequencing relies on div_done.
  logic unused_div_busy_s;
  assign unused_div_busy_s = div_busy;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign dvd_arr_s[g] = req_dividend[g*DATA_W +: DATA_W];
    assign dvs_arr_s[g] = req_divisor[g*DATA_W +: DATA_W];
  end

  assign wdog_inc_s = wdog_q + WD_W'(1);

  // Round-robin search: first asserted req at or above rr_ptr, wrapping.
  always_comb begin
    logic [PTR_W:0] cand;
    logic [PTR_W:0] cand_nxt;
    found_s    = 1'b0;
    win_s      = rr_ptr_q;
    win_next_s = rr_ptr_q;
    cand       = '0;
    cand_nxt   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
      cand     = (cand >= NREQ_EXT) ? (cand - NREQ_EXT) : cand;
      cand_nxt = cand + (PTR_W + 1)'(1);
      cand_nxt = (cand_nxt >= NREQ_EXT) ? '0 : cand_nxt;
      if (!found_s && req[cand[PTR_W-1:0]]) begin
        found_s    = 1'b1;
        win_s      = cand[PTR_W-1:0];
        win_next_s = cand_nxt[PTR_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and next-output logic; all outputs come straight from flops.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    owner_d         = owner_q;
    dividend_d      = dividend_q;
    divisor_d       = divisor_q;
    wdog_d          = wdog_q;
    gnt_d           = '0;
    rsp_valid_d     = '0;
    rsp_quotient_d  = rsp_quotient_q;
    rsp_remainder_d = rsp_remainder_q;
    rsp_dbz_d       = rsp_dbz_q;
    rsp_timeout_d   = rsp_timeout_q;
    div_start_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d     = ST_ISSUE;
          owner_d     = win_s;
          rr_ptr_d    = win_next_s;
          dividend_d  = dvd_arr_s[win_s];
          divisor_d   = dvs_arr_s[win_s];
          gnt_d       = ONE_HOT0 << win_s;
          div_start_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        wdog_d  = '0;
      end
      ST_WAIT: begin
        wdog_d = wdog_inc_s;
        // A real completion wins over a watchdog expiry in the same cycle.
        if (div_done) begin
          state_d         = ST_RESPOND;
          rsp_valid_d     = ONE_HOT0 << owner_q;
          rsp_quotient_d  = div_quotient;
          rsp_remainder_d = div_remainder;
          rsp_dbz_d       = div_dbz;
          rsp_timeout_d   = 1'b0;
        end else if (wdog_inc_s == WD_LIMIT) begin
          state_d         = ST_RESPOND;
          rsp_valid_d     = ONE_HOT0 << owner_q;
          rsp_quotient_d  = '1;
          rsp_remainder_d = dividend_q;
          rsp_dbz_d       = 1'b0;
          rsp_timeout_d   = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ctrl_busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      rr_ptr_q        <= '0;
      owner_q         <= '0;
      dividend_q      <= '0;
      divisor_q       <= '0;
      wdog_q          <= '0;
      gnt_q           <= '0;
      rsp_valid_q     <= '0;
      rsp_quotient_q  <= '0;
      rsp_remainder_q <= '0;
      rsp_dbz_q       <= 1'b0;
      rsp_timeout_q   <= 1'b0;
      ctrl_busy_q     <= 1'b0;
      div_start_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      owner_q         <= owner_d;
      dividend_q      <= dividend_d;
      divisor_q       <= divisor_d;
      wdog_q          <= wdog_d;
      gnt_q           <= gnt_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_quotient_q  <= rsp_quotient_d;
      rsp_remainder_q <= rsp_remainder_d;
      rsp_dbz_q       <= rsp_dbz_d;
      rsp_timeout_q   <= rsp_timeout_d;
      ctrl_busy_q     <= ctrl_busy_d;
      div_start_q     <= div_start_d;
    end
  end

  assign gnt           = gnt_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_quotient  = rsp_quotient_q;
  assign rsp_remainder = rsp_remainder_q;
  assign rsp_dbz       = rsp_dbz_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign ctrl_busy     = ctrl_busy_q;
  assign div_start     = div_start_q;
  assign div_dividend  = dividend_q;
  assign div_divisor   = divisor_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: a behavioural divider, a transaction-level reference model
// checked every cycle, and directed scenarios with hand-computed latencies and results.
module tb_divider_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_dividend = '0;
  logic [NUM_REQ*DATA_W-1:0] req_divisor = '0;
  logic [NUM_REQ-1:0]        gnt, rsp_valid;
  logic [DATA_W-1:0]         rsp_quotient, rsp_remainder;
  logic                      rsp_dbz, rsp_timeout, ctrl_busy, div_start;
  logic [DATA_W-1:0]         div_dividend, div_divisor;
  logic                      div_busy = 1'b0, div_done = 1'b0, div_dbz = 1'b0;
  logic [DATA_W-1:0]         div_quotient = '0, div_remainder = '0;

  divider_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dbz(rsp_dbz), .rsp_timeout(rsp_timeout), .ctrl_busy(ctrl_busy), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_busy(div_busy),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_dbz(div_dbz)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit hang = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Divider: done 9 cycles after start, reading its operands at finish; never finishes when hang=1.
  int div_cnt = 0;
  initial forever begin
    @(posedge clk);
    #1;
    div_done = 1'b0;
    if (reset) begin
      div_cnt = 0;
    end else begin
      if (div_cnt > 0) begin
        div_cnt--;
        if (div_cnt == 0 && !hang) begin
          div_done = 1'b1;
          if (div_divisor == 8'd0) begin
            div_quotient = 8'hFF; div_remainder = div_dividend; div_dbz = 1'b1;
          end else begin
            div_quotient = div_dividend / div_divisor;
            div_remainder = div_dividend % div_divisor;
            div_dbz = 1'b0;
          end
        end
      end
      if (div_start) div_cnt = 9;
    end
    div_busy = (div_cnt > 0);
  end

  // Reference model: one transaction at a time, described by grant/response cycles.
  int m_gnt = -1, m_rsp = -1, m_free = 0, m_ptr = 0, m_owner = 0, idx;
  bit found;
  logic [7:0] m_dvd, m_dvs, m_q, m_r;
  bit m_dbz, m_to;
  logic [7:0] e_dvd = 0, e_dvs = 0, e_q = 0, e_r = 0;
  bit e_dbz = 0, e_to = 0, e_busy = 0, e_start = 0;
  logic [NUM_REQ-1:0] e_gnt = 0, e_rsp = 0;

  always @(negedge clk) begin
    if (reset) begin
      m_gnt = -1; m_rsp = -1; m_free = 0; m_ptr = 0;
      e_dvd = 0; e_dvs = 0; e_q = 0; e_r = 0; e_dbz = 0; e_to = 0;
      e_busy = 0; e_start = 0; e_gnt = 0; e_rsp = 0;
    end else begin
      e_gnt   = (cyc == m_gnt) ? (NUM_REQ'(1) << m_owner) : '0;
      e_rsp   = (cyc == m_rsp) ? (NUM_REQ'(1) << m_owner) : '0;
      e_start = (cyc == m_gnt);
      e_busy  = (cyc >= m_gnt) && (cyc <= m_rsp);
      if (cyc == m_gnt) begin e_dvd = m_dvd; e_dvs = m_dvs; end
      if (cyc == m_rsp) begin e_q = m_q; e_r = m_r; e_dbz = m_dbz; e_to = m_to; end
    end
    check("gnt", gnt, e_gnt);
    check("rsp_valid", rsp_valid, e_rsp);
    check("div_start", div_start, e_start);
    check("ctrl_busy", ctrl_busy, e_busy);
    check("div_dividend", div_dividend, e_dvd);
    check("div_divisor", div_divisor, e_dvs);
    check("rsp_quotient", rsp_quotient, e_q);
    check("rsp_remainder", rsp_remainder, e_r);
    check("rsp_dbz", rsp_dbz, e_dbz);
    check("rsp_timeout", rsp_timeout, e_to);
    if (!reset && cyc >= m_free && |req) begin
      found = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (!found && req[idx]) begin found = 1; m_owner = idx; end
      end
      m_ptr = (m_owner + 1) % NUM_REQ;
      m_dvd = req_dividend[m_owner*DATA_W +: DATA_W];
      m_dvs = req_divisor[m_owner*DATA_W +: DATA_W];
      m_gnt = cyc + 1;
      if (hang) begin
        m_rsp = m_gnt + TIMEOUT + 1; m_q = 8'hFF; m_r = m_dvd; m_dbz = 0; m_to = 1;
      end else begin
        m_rsp = m_gnt + 10; m_to = 0;
        if (m_dvs == 0) begin m_q = 8'hFF; m_r = m_dvd; m_dbz = 1; end
        else begin m_q = m_dvd / m_dvs; m_r = m_dvd % m_dvs; m_dbz = 0; end
      end
      m_free = m_rsp + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] dvd, input logic [7:0] dvs);
    req_dividend[i*DATA_W +: DATA_W] = dvd;
    req_divisor[i*DATA_W +: DATA_W]  = dvs;
    req[i] = 1'b1;
  endtask

  task automatic wait_gnt(input int i, output int at);
    int n = 0;
    while (n < 60 && !gnt[i]) begin tick(); n++; end
    check("gnt_wait", gnt[i], 1'b1);
    at = cyc;
  endtask

  task automatic wait_rsp(input int i, output int at);
    int n = 0;
    while (n < 60 && !rsp_valid[i]) begin tick(); n++; end
    check("rsp_wait", rsp_valid[i], 1'b1);
    at = cyc;
  endtask

  int t0, g, r, prev, cnt;
  int order [4] = '{1, 0, 1, 0};

  initial begin
    tick(); tick();
    check("rst_busy", ctrl_busy, 1'b0);
    check("rst_gnt", gnt, 2'b00);
    check("rst_quot", rsp_quotient, 8'h00);
    reset = 1'b0;
    tick();

    // T2: both held, rr_ptr=0 -> req0 then req1
    t0 = cyc; set_req(0, 8'd200, 8'd10); set_req(1, 8'd9, 8'd4);
    wait_gnt(0, g); check("t2_gnt0_lat", g - t0, 1);
    tick(); req[0] = 1'b0;
    wait_rsp(0, r); check("t2_rsp0_lat", r - t0, 11);
    check("t2_q0", rsp_quotient, 8'd20); check("t2_r0", rsp_remainder, 8'd0);
    wait_gnt(1, g); check("t2_gnt1_lat", g - t0, 13);
    tick(); req[1] = 1'b0;
    wait_rsp(1, r); check("t2_rsp1_lat", r - t0, 23);
    check("t2_q1", rsp_quotient, 8'd2); check("t2_r1", rsp_remainder, 8'd1);
    tick(); tick();

    // T1: 100/7 on requester 0
    t0 = cyc; set_req(0, 8'd100, 8'd7);
    wait_gnt(0, g); check("t1_gnt_lat", g - t0, 1);
    tick(); req[0] = 1'b0;
    wait_rsp(0, r); check("t1_rsp_lat", r - t0, 11);
    check("t1_q", rsp_quotient, 8'd14); check("t1_r", rsp_remainder, 8'd2);
    check("t1_dbz", rsp_dbz, 1'b0);
    tick(); tick();

    // T3: divide by zero on requester 1
    t0 = cyc; set_req(1, 8'h5A, 8'h00);
    wait_gnt(1, g); tick(); req[1] = 1'b0;
    wait_rsp(1, r); check("t3_rsp_lat", r - t0, 11);
    check("t3_q", rsp_quotient, 8'hFF); check("t3_r", rsp_remainder, 8'h5A);
    check("t3_dbz", rsp_dbz, 1'b1); check("t3_to", rsp_timeout, 1'b0);
    tick(); tick();

    // T4: divider hangs -> watchdog response
    hang = 1'b1;
    t0 = cyc; set_req(0, 8'd50, 8'd5);
    wait_gnt(0, g); tick(); req[0] = 1'b0;
    wait_rsp(0, r); check("t4_rsp_lat", r - t0, 17);
    check("t4_to", rsp_timeout, 1'b1); check("t4_q", rsp_quotient, 8'hFF);
    check("t4_r", rsp_remainder, 8'd50); check("t4_dbz", rsp_dbz, 1'b0);
    tick(); tick(); hang = 1'b0;

    // T5: reset while waiting on the divider
    set_req(1, 8'd100, 8'd3);
    wait_gnt(1, g); tick(); req[1] = 1'b0;
    repeat (4) tick();
    reset = 1'b1; #1;
    check("t5_busy", ctrl_busy, 1'b0); check("t5_quot", rsp_quotient, 8'h00);
    check("t5_dvd", div_dividend, 8'h00); check("t5_to", rsp_timeout, 1'b0);
    tick(); tick(); reset = 1'b0;
    cnt = 0;
    repeat (20) begin tick(); cnt += int'(|rsp_valid); end
    check("t5_no_rsp", cnt, 0);
    t0 = cyc; set_req(0, 8'd33, 8'd5);
    wait_gnt(0, g); check("t5_gnt_lat", g - t0, 1);
    tick(); req[0] = 1'b0;
    wait_rsp(0, r); check("t5_rsp_lat", r - t0, 11);
    check("t5_q", rsp_quotient, 8'd6); check("t5_r", rsp_remainder, 8'd3);
    tick(); tick();

    // T6: req1 pulsed while req0 is in service is withdrawn
    t0 = cyc; set_req(0, 8'd200, 8'd7);
    wait_gnt(0, g); tick(); req[0] = 1'b0;
    repeat (3) tick();
    set_req(1, 8'd77, 8'd7); tick(); req[1] = 1'b0;
    wait_rsp(0, r); check("t6_rsp_lat", r - t0, 11);
    check("t6_q", rsp_quotient, 8'd28); check("t6_r", rsp_remainder, 8'd4);
    cnt = 0;
    repeat (20) begin tick(); cnt += int'(gnt[1] | rsp_valid[1]); end
    check("t6_no_req1", cnt, 0);

    // T7: both held continuously -> grants alternate every 12 cycles
    set_req(0, 8'd81, 8'd9); set_req(1, 8'd255, 8'd16);
    prev = 0;
    for (int j = 0; j < 4; j++) begin
      wait_gnt(order[j], g);
      if (j > 0) check("t7_spacing", g - prev, 12);
      prev = g;
      tick();
    end
    req = '0;
    wait_rsp(0, r);
    check("t7_q", rsp_quotient, 8'd9); check("t7_r", rsp_remainder, 8'd0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
